// File: rtl/sync_fifo_flags_if.sv
// Write/read handshake and status bundle for sync_fifo_flags.
// Handshake: write_enable/read_enable are requests; they take effect only when accepted (see overflow/underflow).
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZE_BITS  = 3
);
  logic [DATA_WIDTH-1:0] data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [SIZE_BITS:0]    fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data, write_enable, read_enable,
    input  q, q_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );

  modport slave (
    input  data, write_enable, read_enable,
    output q, q_valid, fifo_full, fifo_empty, almost_full, almost_empty,
           fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with registered flags, thresholds, occupancy and overflow/underflow pulses.
// Define FIFO_SHOWAHEAD_EN for first-word fall-through; default is a one-cycle registered read.
module sync_fifo_flags #(
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_SIZE           = 8,
  parameter int SIZE_BITS           = 3,
  parameter int ALMOST_FULL_THRESH  = 6,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input logic clock,
  input logic reset,
  sync_fifo_flags_if.slave bus
);
  localparam int CW = SIZE_BITS + 1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_SIZE);
  localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_TH    = CW'(ALMOST_EMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [CW-1:0]         wr_ptr, rd_ptr, count, count_next;
  logic [SIZE_BITS-1:0]  wr_idx, rd_idx;
  logic                  wr_acc, rd_acc;
  logic                  full_r, empty_r, af_r, ae_r, ovf_r, unf_r;

  assign wr_idx = wr_ptr[SIZE_BITS-1:0];
  assign rd_idx = rd_ptr[SIZE_BITS-1:0];

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
  always_comb begin
    rd_acc     = bus.read_enable & ~empty_r;
    wr_acc     = bus.write_enable & (~full_r | rd_acc);
    count_next = count;
    if (wr_acc && !rd_acc)      count_next = count + ONE;
    else if (!wr_acc && rd_acc) count_next = count - ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      af_r    <= (AF_TH == '0);
      ae_r    <= 1'b1;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count   <= count_next;
      // Flags come from the post-edge count so they never lag the occupancy.
      full_r  <= (count_next == FULL_CNT);
      empty_r <= (count_next == '0);
      af_r    <= (count_next >= AF_TH);
      ae_r    <= (count_next <= AE_TH);
      ovf_r   <= bus.write_enable & ~wr_acc;
      unf_r   <= bus.read_enable & ~rd_acc;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_acc && !reset) mem[wr_idx] <= bus.data;
  end

`ifdef FIFO_SHOWAHEAD_EN
  assign bus.q       = mem[rd_idx];
  assign bus.q_valid = ~empty_r;
`else
  logic [DATA_WIDTH-1:0] q_r;
  logic                  q_valid_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
    end else begin
      if (rd_acc) q_r <= mem[rd_idx];
      q_valid_r <= rd_acc;
    end
  end

  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
`endif

  assign bus.fifo_full    = full_r;
  assign bus.fifo_empty   = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.fill_count   = count;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: constant vector table, directed corner sequences, and randomized
// traffic against a queue-based reference model.
module tb_sync_fifo_flags;
  localparam int DW = 32;
  localparam int SB = 3;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .SIZE_BITS(SB)) bus ();

  sync_fifo_flags #(
    .DATA_WIDTH(DW), .FIFO_SIZE(DEPTH), .SIZE_BITS(SB),
    .ALMOST_FULL_THRESH(6), .ALMOST_EMPTY_THRESH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO contents as a plain queue.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_word;
  logic          exp_qv, exp_ovf, exp_unf;

  typedef struct {
    logic          we;
    logic          re;
    logic [DW-1:0] d;
    logic [SB:0]   cnt;
    logic          full, empty, af, ae, ovf, unf, qv;
    logic [DW-1:0] q;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic compare_model();
    int n;
    n = exp_q.size();
    check("fill_count", 64'(bus.fill_count), 64'(n));
    check("fifo_full", 64'(bus.fifo_full), 64'(n == DEPTH));
    check("fifo_empty", 64'(bus.fifo_empty), 64'(n == 0));
    check("almost_full", 64'(bus.almost_full), 64'(n >= 6));
    check("almost_empty", 64'(bus.almost_empty), 64'(n <= 2));
    check("overflow", 64'(bus.overflow), 64'(exp_ovf));
    check("underflow", 64'(bus.underflow), 64'(exp_unf));
`ifdef FIFO_SHOWAHEAD_EN
    check("q_valid", 64'(bus.q_valid), 64'(n > 0));
    if (n > 0) check("q_head", 64'(bus.q), 64'(exp_q[0]));
`else
    check("q_valid", 64'(bus.q_valid), 64'(exp_qv));
    check("q", 64'(bus.q), 64'(exp_word));
`endif
  endtask

  // One clock of traffic: update the model from the accept rules, then compare.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
    logic rd_ok, wr_ok;
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.data         = d;
    rd_ok = re && (exp_q.size() > 0);
    wr_ok = we && ((exp_q.size() < DEPTH) || rd_ok);
    exp_qv  = rd_ok;
    exp_ovf = we && !wr_ok;
    exp_unf = re && !rd_ok;
    if (rd_ok) exp_word = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.write_enable = 1'b1;
    bus.read_enable  = 1'b1;
    bus.data         = DW'($urandom);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    exp_q.delete();
    exp_word = '0;
    exp_qv = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    compare_model();
  endtask

  initial begin
    bool_init: begin
      bus.data = '0; bus.write_enable = 1'b0; bus.read_enable = 1'b0;
    end
    // we re data cnt full empty af ae ovf unf qv q
    vecs[0]  = '{1'b1, 1'b0, 32'hA0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'hA1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'hA2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'hA3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'hA4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'hA5, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'hA6, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'hA7, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'hFF, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 1'b0, 32'h00, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 32'hB0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};

    // Power-on reset, then the fill / overflow / full read+write table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].we, vecs[i].re, vecs[i].d);
      check($sformatf("vec%0d_count", i), 64'(bus.fill_count), 64'(vecs[i].cnt));
      check($sformatf("vec%0d_full", i), 64'(bus.fifo_full), 64'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 64'(bus.fifo_empty), 64'(vecs[i].empty));
      check($sformatf("vec%0d_af", i), 64'(bus.almost_full), 64'(vecs[i].af));
      check($sformatf("vec%0d_ae", i), 64'(bus.almost_empty), 64'(vecs[i].ae));
      check($sformatf("vec%0d_ovf", i), 64'(bus.overflow), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_unf", i), 64'(bus.underflow), 64'(vecs[i].unf));
`ifndef FIFO_SHOWAHEAD_EN
      check($sformatf("vec%0d_qv", i), 64'(bus.q_valid), 64'(vecs[i].qv));
      check($sformatf("vec%0d_q", i), 64'(bus.q), 64'(vecs[i].q));
`endif
    end

    // Drain: A1..A7 then B0 last, never the rejected 0xFF.
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_SHOWAHEAD_EN
      if (i == 7) check("drain_last_head", 64'(bus.q), 64'h0B0);
`endif
      step(1'b0, 1'b1, '0);
      check("drain_not_ff", 64'(bus.q == 32'hFF), 64'(0));
`ifndef FIFO_SHOWAHEAD_EN
      if (i == 7) check("drain_last", 64'(bus.q), 64'h0B0);
`endif
    end
    check("drained_empty", 64'(bus.fifo_empty), 64'(1));
    step(1'b0, 1'b1, '0);
    check("read_empty_unf", 64'(bus.underflow), 64'(1));

    // Empty plus simultaneous read and write.
    step(1'b1, 1'b1, 32'hC1);
    check("empty_rw_unf", 64'(bus.underflow), 64'(1));
    check("empty_rw_count", 64'(bus.fill_count), 64'(1));
`ifndef FIFO_SHOWAHEAD_EN
    check("empty_rw_qv", 64'(bus.q_valid), 64'(0));
`endif
    step(1'b0, 1'b1, '0);
`ifndef FIFO_SHOWAHEAD_EN
    check("c1_read", 64'(bus.q), 64'h0C1);
`endif

    // Pointer wrap with occupancy held between 1 and 3.
    begin
      logic full_seen;
      full_seen = 1'b0;
      step(1'b1, 1'b0, 32'h00);
      step(1'b1, 1'b0, 32'h01);
      full_seen |= bus.fifo_full;
      for (int i = 2; i < 20; i++) begin
        step(1'b1, (i % 3) != 0 || exp_q.size() >= 3, DW'(i));
        full_seen |= bus.fifo_full;
      end
      while (exp_q.size() > 0) step(1'b0, 1'b1, '0);
      check("wrap_full_never", 64'(full_seen), 64'(0));
    end

    // Reset at count 5 with both requests active.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(32'h50 + i));
    check("pre_reset_count", 64'(bus.fill_count), 64'(5));
    do_reset();
    check("rst_count", 64'(bus.fill_count), 64'(0));
    check("rst_empty", 64'(bus.fifo_empty), 64'(1));
    check("rst_qv", 64'(bus.q_valid), 64'(0));
    check("rst_ovf_unf", 64'({bus.overflow, bus.underflow}), 64'(0));
    step(1'b1, 1'b0, 32'hA0);
`ifdef FIFO_SHOWAHEAD_EN
    check("fwft_q", 64'(bus.q), 64'h0A0);
    check("fwft_qv", 64'(bus.q_valid), 64'(1));
`else
    check("reg_qv_after_write", 64'(bus.q_valid), 64'(0));
`endif

    // Randomized traffic: fill-biased, drain-biased, then balanced with occasional resets.
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 250; i++) begin
        int wp, rp;
        wp = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
        rp = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
        if (phase == 2 && $urandom_range(0, 99) < 2) do_reset();
        else step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO with registered status flags, programmable almost-full and almost-empty thresholds, and an occupancy count. It detects overflow and underflow, and handles simultaneous read and write at the full and empty boundaries. It replaces the dual-clock-pin FIFO for same-domain buffering between datapath stages.

Parameters:
DATA_WIDTH, 32, width of each stored word
FIFO_SIZE, 8, depth in words; must equal 2**SIZE_BITS
SIZE_BITS, 3, address width; pointers and count are SIZE_BITS+1 bits wide
ALMOST_FULL_THRESH, 6, almost_full asserts when fill_count >= this value
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when fill_count <= this value

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock
data  input  DATA_WIDTH  write data
write_enable  input  1  write request
read_enable  input  1  read request
q  output  DATA_WIDTH  read data
q_valid  output  1  q holds a freshly read word
fifo_full  output  1  fill_count == FIFO_SIZE
fifo_empty  output  1  fill_count == 0
almost_full  output  1  fill_count >= ALMOST_FULL_THRESH
almost_empty  output  1  fill_count <= ALMOST_EMPTY_THRESH
fill_count  output  SIZE_BITS+1  current occupancy, 0..FIFO_SIZE
overflow  output  1  one-cycle pulse: write was rejected
underflow  output  1  one-cycle pulse: read was rejected

Behaviour:
- Reset values (synchronous):
  - pointers = 0, fill_count = 0, q = 0, q_valid = 0
  - fifo_empty = 1, fifo_full = 0
  - almost_empty = 1, almost_full = 0 (for ALMOST_FULL_THRESH > 0)
  - overflow = 0, underflow = 0
  - Memory contents are not reset.
- Reset takes priority over all requests in the same cycle. Reset mid-stream discards all contents, and the next cycle behaves as empty.
- Pointers are SIZE_BITS+1 bits. The MSB is the wrap bit; the low SIZE_BITS bits index memory. Both pointers wrap naturally modulo 2*FIFO_SIZE.
- Accept rules:
  - wr_acc = write_enable & (!fifo_full | rd_acc)
  - rd_acc = read_enable & !fifo_empty
- Full plus simultaneous read and write: both are accepted. fill_count is unchanged, q gets the old head word, and the new word is stored in the freed slot.
- Empty plus simultaneous read and write: the read is rejected and underflow pulses. The write is accepted and fill_count becomes 1. No write-through bypass.
- Write full with no read: the write is rejected, overflow pulses for one cycle, and memory and pointers are unchanged.
- Read empty: underflow pulses, and q and read_pointer are unchanged.
- fill_count next = fill_count + wr_acc - rd_acc.
- All flags are registered and computed from the next fill_count, so they are exact in the cycle after the edge. No lag.
- Read latency (default build): on the edge with rd_acc, q <= mem[read_pointer] and q_valid <= 1. q_valid is 0 after any edge without rd_acc. q holds its last value when idle.

Optional Feature:
FIFO_SHOWAHEAD_EN
- Defined (first-word fall-through):
  - q always presents mem[read_pointer] (the head word); q_valid = !fifo_empty.
  - read_enable acknowledges and pops the head, so the next word appears after that edge.
  - A word written into an empty FIFO appears on q in the cycle after its write edge.
  - Underflow and overflow rules are unchanged. q is don't-care while q_valid = 0.
- Undefined: registered read with one-cycle latency, as described under Behaviour.

Test Plan:
1. Reset, then write 0xA0..0xA7 on 8 consecutive cycles. Required: fill_count steps 1..8; almost_empty deasserts when count reaches 3; almost_full asserts at count 6; fifo_full asserts at count 8.
2. From full, issue one write of 0xFF with no read. Required: overflow = 1 for exactly one cycle; fill_count stays 8; a subsequent drain returns 0xA0..0xA7 in order with no 0xFF.
3. From full, read and write 0xB0 in the same cycle. Required: q = 0xA0 with q_valid = 1; fill_count = 8; after draining, 0xB0 is the last word out.
4. From empty, read and write 0xC1 in the same cycle. Required: underflow pulses; q_valid = 0; fill_count = 1; the next read returns 0xC1.
5. Wrap: push and pop 20 words (0x00..0x13) while keeping occupancy between 1 and 3. Required: output order matches input order across the pointer wrap; fifo_full never asserts.
6. Assert reset at count 5 together with write_enable and read_enable. Required: next cycle fill_count = 0, fifo_empty = 1, q_valid = 0, and no overflow or underflow pulse. With FIFO_SHOWAHEAD_EN, rerun scenario 1: q = 0xA0 and q_valid = 1 the cycle after the first write.
